// File: rtl/svlog_alu_amba.sv
// AXI4-Lite slave ALU: add/sub/and/or/xor plus an iterative shift-add multiplier.
// Software loads OPA/OPB, writes CTRL to start, polls STATUS and reads RESULT/RESULT_HI.
module svlog_alu_amba #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int OPERAND_WIDTH      = 32,
   parameter int NUM_LEDS           = 4,
   parameter bit MUL_EN             = 1'b1
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_LEDS-1:0]             o_leds
);
   localparam int W = OPERAND_WIDTH;
   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                          OP_OR  = 3'b011, OP_XOR = 3'b100, OP_MUL = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t           state_q, state_d;
   logic             aw_held_q, w_held_q, bvalid_q, rvalid_q;
   logic [2:0]       waddr_q;
   logic [31:0]      wdata_q, rdata_q, opa_q, opb_q, leds_q;
   logic [3:0]       wstrb_q;
   logic [2:0]       opcode_q, op_q;
   logic             err_q, done_q;
   logic [W-1:0]     a_q, b_q, result_q, result_hi_q;
   logic [2*W-1:0]   acc_q;
   logic [5:0]       cnt_q;

   logic             do_write, b_hs, ctrl_wr, start_req, start_ok, start_bad, busy, finish;
   logic [2:0]       op_new;
   logic [W:0]       sum_ext, diff_ext;
   logic [2*W-1:0]   mul_next;
   logic [W-1:0]     res_lo, res_hi;
   logic [31:0]      ctrl_rd, rd_val;
   logic             unused_ok;

   function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

   function automatic logic legal_op(input logic [2:0] op);
      return (op <= OP_XOR) || ((op == OP_MUL) && MUL_EN);
   endfunction

   // Protection bits and the byte offset within a word carry no meaning here.
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign busy      = (state_q != S_IDLE);
   assign do_write  = aw_held_q && w_held_q && !bvalid_q;
   assign b_hs      = bvalid_q && s00_axi_bready;
   assign ctrl_wr   = do_write && (waddr_q == 3'd3);
   assign op_new    = wstrb_q[0] ? wdata_q[3:1] : opcode_q;
   assign start_req = ctrl_wr && wstrb_q[0] && wdata_q[0];
   assign start_ok  = start_req && !busy && legal_op(op_new);
   assign start_bad = start_req && !start_ok;
   assign finish    = (state_q == S_EXEC) || ((state_q == S_MUL) && (cnt_q == '0));

   assign s00_axi_awready = !aw_held_q && !s00_axi_areset;
   assign s00_axi_wready  = !w_held_q && !s00_axi_areset;
   assign s00_axi_arready = !rvalid_q && !s00_axi_areset;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_rresp   = 2'b00;
   assign o_leds          = leds_q[NUM_LEDS-1:0];

   // NOTE: sequential state uses <= so every register samples pre-edge values, race-free.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         aw_held_q <= 1'b0;  w_held_q <= 1'b0;  bvalid_q <= 1'b0;  rvalid_q <= 1'b0;
         waddr_q   <= '0;    wdata_q  <= '0;    wstrb_q  <= '0;    rdata_q  <= '0;
         opa_q     <= '0;    opb_q    <= '0;    leds_q   <= '0;    opcode_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (s00_axi_awvalid && s00_axi_awready) begin
            aw_held_q <= 1'b1;
            waddr_q   <= s00_axi_awaddr[4:2];
         end
         if (s00_axi_wvalid && s00_axi_wready) begin
            w_held_q <= 1'b1;
            wdata_q  <= s00_axi_wdata;
            wstrb_q  <= s00_axi_wstrb;
         end
         if (do_write) bvalid_q <= 1'b1;
         if (b_hs) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
         if (do_write) begin
            case (waddr_q)
               3'd0:    opa_q  <= apply_strb(opa_q, wdata_q, wstrb_q);
               3'd1:    opb_q  <= apply_strb(opb_q, wdata_q, wstrb_q);
               3'd4:    leds_q <= apply_strb(leds_q, wdata_q, wstrb_q);
               default: ;
            endcase
         end
         if (ctrl_wr) opcode_q <= op_new;
         // A rejected start wins over a simultaneous write-1-to-clear.
         if (start_bad)                                   err_q <= 1'b1;
         else if (ctrl_wr && wstrb_q[3] && wdata_q[29])   err_q <= 1'b0;
         if (s00_axi_arvalid && s00_axi_arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
         end else if (rvalid_q && s00_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = (op_new == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC:  state_d = S_IDLE;
         S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // MSB-first shift-add: acc doubles each step and adds A when the current B bit is set.
   always_comb begin
      sum_ext  = {1'b0, a_q} + {1'b0, b_q};
      diff_ext = {1'b0, a_q} - {1'b0, b_q};
      mul_next = {acc_q[2*W-2:0], 1'b0} + (b_q[W-1] ? {{W{1'b0}}, a_q} : '0);
      res_lo   = '0;
      res_hi   = '0;
      case (op_q)
         OP_ADD:  begin res_lo = sum_ext[W-1:0];  res_hi[0] = sum_ext[W];  end
         OP_SUB:  begin res_lo = diff_ext[W-1:0]; res_hi[0] = diff_ext[W]; end
         OP_AND:  res_lo = a_q & b_q;
         OP_OR:   res_lo = a_q | b_q;
         OP_XOR:  res_lo = a_q ^ b_q;
         OP_MUL:  {res_hi, res_lo} = mul_next;
         default: ;
      endcase
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         a_q <= '0;  b_q <= '0;  op_q <= '0;  acc_q <= '0;  cnt_q <= '0;
         result_q <= '0;  result_hi_q <= '0;  done_q <= 1'b0;
      end else if (start_ok) begin
         a_q    <= opa_q[W-1:0];
         b_q    <= opb_q[W-1:0];
         op_q   <= op_new;
         acc_q  <= '0;
         cnt_q  <= 6'(W - 1);
         done_q <= 1'b0;
      end else begin
         if (state_q == S_MUL) begin
            acc_q <= mul_next;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - 6'd1;
         end
         if (finish) begin
            result_q    <= res_lo;
            result_hi_q <= res_hi;
            done_q      <= 1'b1;
         end
      end
   end

   always_comb begin
      ctrl_rd      = '0;
      ctrl_rd[31]  = done_q;
      ctrl_rd[30]  = busy;
      ctrl_rd[29]  = err_q;
      ctrl_rd[3:1] = opcode_q;
      rd_val       = '0;
      case (s00_axi_araddr[4:2])
         3'd0:    rd_val = opa_q;
         3'd1:    rd_val = opb_q;
         3'd2:    rd_val[W-1:0] = result_q;
         3'd3:    rd_val = ctrl_rd;
         3'd4:    rd_val = leds_q;
         3'd5:    rd_val[W-1:0] = result_hi_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_svlog_alu_amba.sv
// Directed bench for svlog_alu_amba: reads push expected data into a scoreboard that a
// monitor drains on every R-channel handshake; write responses are counted by the same monitor.
module tb_svlog_alu_amba;
   localparam int W = 32;
   localparam logic [4:0] A_OPA = 5'h00, A_OPB = 5'h04, A_RES = 5'h08, A_CTRL = 5'h0C,
                          A_LEDS = 5'h10, A_RHI = 5'h14, A_U0 = 5'h18, A_U1 = 5'h1C;

   logic        clk = 1'b0;
   logic        areset;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [3:0]  leds;

   int          checks = 0, failures = 0, b_count = 0, cyc = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   string       mon_name;
   logic [31:0] mon_exp;

   svlog_alu_amba dut (
      .s00_axi_aclk(clk),       .s00_axi_areset(areset),
      .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),   .s00_axi_wvalid(wvalid),   .s00_axi_wready(wready),
      .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),   .s00_axi_rvalid(rvalid),   .s00_axi_rready(rready),
      .o_leds(leds)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: actual=timeout required=handshake", name);
   endtask

   // Monitor: compares every read beat against the scoreboard, counts write responses.
   initial begin
      forever begin
         @(negedge clk);
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_read: actual=0x%08h required=no_beat", rdata);
            end else begin
               mon_name = name_q.pop_front();
               mon_exp  = exp_q.pop_front();
               check(mon_name, rdata, mon_exp);
            end
         end
         if (bvalid && bready) b_count++;
      end
   end

   task automatic wait_b(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 20);
      if (!bvalid) timeout(name);
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output int hs);
      int n = 0;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("write_ready");
      @(posedge clk); #1;
      hs = cyc;
      awvalid = 1'b0; wvalid = 1'b0;
      wait_b("write_bvalid");
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      int hs;
      axi_write(addr, data, 4'hF, hs);
   endtask

   // Read whose AR handshake lands no earlier than edge at_edge (0 = as soon as possible).
   task automatic axi_read(input string name, input logic [4:0] addr, input logic [31:0] exp,
                           input int at_edge);
      int n = 0;
      @(negedge clk);
      while (cyc < at_edge - 1) @(negedge clk);
      name_q.push_back(name);
      exp_q.push_back(exp);
      araddr = addr; arvalid = 1'b1;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout({name, "_arready"});
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (!rvalid) timeout({name, "_rvalid"});
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=no_finish required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs, e0, b_before;
      areset = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0; wstrb = '0;
      bready = 1'b1; rready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_leds", leds, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      @(negedge clk); areset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_awready", awready, 1);
      axi_read("rst_status", A_CTRL, 32'h0, 0);
      axi_read("rst_opa", A_OPA, 32'h0, 0);
      axi_read("rst_result", A_RES, 32'h0, 0);

      // 1: sub 2-1; status read on the done-setting edge sees pre-edge busy=1, done=0
      wr(A_OPA, 32'd2);
      wr(A_OPB, 32'd1);
      e0 = cyc + 1;
      fork
         axi_write(A_CTRL, 32'h3, 4'hF, hs);
         axi_read("t1_status_at_done_edge", A_CTRL, 32'h4000_0002, e0 + 2);
      join
      axi_read("t1_result", A_RES, 32'h1, 0);
      axi_read("t1_result_hi", A_RHI, 32'h0, 0);
      axi_read("t1_status_done", A_CTRL, 32'h8000_0002, 0);

      // 2: add with carry out, sub with borrow
      wr(A_OPA, 32'hFFFF_FFFF);
      wr(A_OPB, 32'd2);
      wr(A_CTRL, 32'h1);
      axi_read("t2_add_result", A_RES, 32'h1, 0);
      axi_read("t2_add_carry", A_RHI, 32'h1, 0);
      wr(A_OPA, 32'd1);
      wr(A_CTRL, 32'h3);
      axi_read("t2_sub_result", A_RES, 32'hFFFF_FFFF, 0);
      axi_read("t2_sub_borrow", A_RHI, 32'h1, 0);

      // 3: mul, OPA rewrite while busy, done exactly W+1 edges after the CTRL handshake
      wr(A_OPA, 32'h0001_0000);
      wr(A_OPB, 32'h0003_0000);
      axi_write(A_CTRL, 32'hB, 4'hF, hs);
      axi_read("t3_status_busy", A_CTRL, 32'h4000_000A, 0);
      wr(A_OPA, 32'h1234_5678);
      axi_read("t3_opa_while_busy", A_OPA, 32'h1234_5678, 0);
      axi_read("t3_status_at_done_edge", A_CTRL, 32'h4000_000A, hs + W + 1);
      axi_read("t3_status_done", A_CTRL, 32'h8000_000A, 0);
      axi_read("t3_result", A_RES, 32'h0, 0);
      axi_read("t3_result_hi", A_RHI, 32'h3, 0);

      // 4: start while busy sets err and leaves the running mul alone; write-1 clears err
      wr(A_OPA, 32'd3);
      wr(A_OPB, 32'd5);
      wr(A_CTRL, 32'hB);
      wr(A_CTRL, 32'hB);
      repeat (40) @(posedge clk);
      #1;
      axi_read("t4_status_err", A_CTRL, 32'hA000_000A, 0);
      axi_read("t4_result", A_RES, 32'd15, 0);
      axi_read("t4_result_hi", A_RHI, 32'h0, 0);
      wr(A_CTRL, 32'h2000_000A);
      axi_read("t4_status_cleared", A_CTRL, 32'h8000_000A, 0);

      // 5: illegal opcode, then AW three cycles ahead of W
      wr(A_CTRL, 32'hF);
      axi_read("t5_status_illegal", A_CTRL, 32'hA000_000E, 0);
      axi_read("t5_result_kept", A_RES, 32'd15, 0);
      b_before = b_count;
      @(negedge clk); awaddr = A_LEDS; awvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0;
      @(negedge clk);
      check("t5_awready_held", awready, 0);
      check("t5_wready_free", wready, 1);
      check("t5_no_early_b", bvalid, 0);
      repeat (2) @(negedge clk);
      wdata = 32'h0000_000F; wstrb = 4'h1; wvalid = 1'b1;
      @(posedge clk); #1; wvalid = 1'b0;
      wait_b("t5_bvalid");
      repeat (3) @(posedge clk);
      #1;
      check("t5_single_b", b_count, b_before + 1);
      check("t5_leds", leds, 4'hF);
      axi_read("t5_leds_read", A_LEDS, 32'hF, 0);
      axi_write(A_OPB, 32'hAABB_CCDD, 4'h6, hs);
      axi_read("t5_opb_strb", A_OPB, 32'h00BB_CC05, 0);
      wr(A_U0, 32'hDEAD_BEEF);
      wr(A_RES, 32'h55);
      axi_read("t5_unmapped0", A_U0, 32'h0, 0);
      axi_read("t5_unmapped1", A_U1, 32'h0, 0);
      axi_read("t5_result_ro", A_RES, 32'd15, 0);

      // 6: reset mid-mul with an AW held and a read beat left open
      wr(A_OPA, 32'd7);
      wr(A_OPB, 32'd9);
      wr(A_CTRL, 32'hB);
      repeat (5) @(posedge clk);
      @(negedge clk); awaddr = A_LEDS; awvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0;
      @(negedge clk); rready = 1'b0; araddr = A_CTRL; arvalid = 1'b1;
      @(posedge clk); #1; arvalid = 1'b0;
      check("t6_read_open", rvalid, 1);
      check("t6_aw_held", awready, 0);
      @(negedge clk); areset = 1'b1;
      @(posedge clk); #1;
      check("t6_rst_rvalid", rvalid, 0);
      check("t6_rst_bvalid", bvalid, 0);
      check("t6_rst_leds", leds, 0);
      check("t6_rst_arready", arready, 0);
      @(negedge clk); areset = 1'b0; rready = 1'b1;
      @(posedge clk); #1;
      check("t6_aw_freed", awready, 1);
      check("t6_w_free", wready, 1);
      axi_read("t6_status", A_CTRL, 32'h0, 0);
      axi_read("t6_leds", A_LEDS, 32'h0, 0);
      axi_read("t6_opa", A_OPA, 32'h0, 0);
      axi_read("t6_result", A_RES, 32'h0, 0);
      axi_read("t6_result_hi", A_RHI, 32'h0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
